// File: rtl/cpu6_tmr_pkg.sv
// Shared constants for the cpu6 machine timer: data width, register word
// offsets inside the 64-byte window, CTRL field layout and the default base.
package cpu6_tmr_pkg;

    localparam int CPU6_XLEN = 32;

    localparam logic [31:0] CPU6_TMR_BASE_DEFAULT = 32'hF000_0000;

    // Register word index = dataaddr[5:2]
    localparam logic [3:0] CPU6_TMR_MTIME_LO    = 4'h0;
    localparam logic [3:0] CPU6_TMR_MTIME_HI    = 4'h1;
    localparam logic [3:0] CPU6_TMR_MTIMECMP_LO = 4'h2;
    localparam logic [3:0] CPU6_TMR_MTIMECMP_HI = 4'h3;
    localparam logic [3:0] CPU6_TMR_CTRL        = 4'h4;
    localparam logic [3:0] CPU6_TMR_STATUS      = 4'h5;

    // CTRL field positions
    localparam int CPU6_TMR_CTRL_EN_BIT    = 0;
    localparam int CPU6_TMR_CTRL_PRESC_LSB = 8;

    typedef struct packed {
        logic [7:0] prescale;
        logic       en;
    } tmr_ctrl_t;

    // Packs the CTRL register into its bus image; unused bits read as zero
    function automatic logic [CPU6_XLEN-1:0] ctrl_image(input tmr_ctrl_t c);
        logic [CPU6_XLEN-1:0] v;
        v = '0;
        v[CPU6_TMR_CTRL_EN_BIT] = c.en;
        v[CPU6_TMR_CTRL_PRESC_LSB +: 8] = c.prescale;
        return v;
    endfunction

endpackage

// File: rtl/cpu6_tmr_prescaler.sv
// Prescaler for mtime: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module cpu6_tmr_prescaler
    import cpu6_tmr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       clear,
    output logic       tick
);

    logic [7:0] precnt;

    assign tick = en && (precnt == prescale);

    // Counter: cleared by reset or a CTRL write, holds while disabled, reloads on tick
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            precnt <= 8'h00;
        end else if (en) begin
            if (precnt == prescale) begin
                precnt <= 8'h00;
            end else begin
                precnt <= precnt + 8'h01;
            end
        end
    end

endmodule

// File: rtl/cpu6_tmr.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp with prescaled counting
// and a registered, MTIE-gated level interrupt toward the cpu6 core.
module cpu6_tmr
    import cpu6_tmr_pkg::*;
#(
    parameter logic [31:0] BASE = CPU6_TMR_BASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CPU6_XLEN-1:0] dataaddr,
    input  logic [CPU6_XLEN-1:0] writedata,
    input  logic                 memwriteM,
    input  logic                 csr_mtie_r,
    output logic                 tmr_sel,
    output logic [CPU6_XLEN-1:0] tmr_rdata,
    output logic                 tmr_irq_r
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    tmr_ctrl_t   ctrl;
    logic [3:0]  reg_idx;
    logic        wr;
    logic        tick;
    logic        pend;
    logic        ctrl_wr;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, dataaddr[1:0]};

    assign tmr_sel = (dataaddr[31:6] == BASE[31:6]);
    assign reg_idx = dataaddr[5:2];
    assign wr      = tmr_sel && memwriteM;
    assign ctrl_wr = wr && (reg_idx == CPU6_TMR_CTRL);
    assign pend    = (mtime >= mtimecmp);

    cpu6_tmr_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl.en),
        .prescale (ctrl.prescale),
        .clear    (ctrl_wr),
        .tick     (tick)
    );

    // mtime: a software write to either half beats the tick in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= 64'h0;
        end else if (wr && (reg_idx == CPU6_TMR_MTIME_LO)) begin
            mtime[31:0] <= writedata;
        end else if (wr && (reg_idx == CPU6_TMR_MTIME_HI)) begin
            mtime[63:32] <= writedata;
        end else if (tick) begin
            mtime <= mtime + 64'h1;
        end
    end

    // mtimecmp and CTRL: plain software-written registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp <= '1;
            ctrl     <= '0;
        end else if (wr) begin
            if (reg_idx == CPU6_TMR_MTIMECMP_LO) mtimecmp[31:0]  <= writedata;
            if (reg_idx == CPU6_TMR_MTIMECMP_HI) mtimecmp[63:32] <= writedata;
            if (reg_idx == CPU6_TMR_CTRL) begin
                ctrl.en       <= writedata[CPU6_TMR_CTRL_EN_BIT];
                ctrl.prescale <= writedata[CPU6_TMR_CTRL_PRESC_LSB +: 8];
            end
        end
    end

    // Interrupt is a registered copy of the compare result gated by MTIE
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_irq_r <= 1'b0;
        end else begin
            tmr_irq_r <= pend && csr_mtie_r;
        end
    end

    // Zero-latency read mux; anything outside the window reads zero
    always_comb begin
        tmr_rdata = '0;
        if (tmr_sel) begin
            case (reg_idx)
                CPU6_TMR_MTIME_LO:    tmr_rdata = mtime[31:0];
                CPU6_TMR_MTIME_HI:    tmr_rdata = mtime[63:32];
                CPU6_TMR_MTIMECMP_LO: tmr_rdata = mtimecmp[31:0];
                CPU6_TMR_MTIMECMP_HI: tmr_rdata = mtimecmp[63:32];
                CPU6_TMR_CTRL:        tmr_rdata = ctrl_image(ctrl);
                CPU6_TMR_STATUS:      tmr_rdata = {30'h0, tmr_irq_r, pend};
                default:              tmr_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_tmr.sv
// Self-checking bench for cpu6_tmr: directed scenarios followed by random
// bus traffic, all checked against a cycle-level behavioural timer model.
module tb_cpu6_tmr;

    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam logic [31:0] A_MLO  = BASE + 32'h00;
    localparam logic [31:0] A_MHI  = BASE + 32'h04;
    localparam logic [31:0] A_CLO  = BASE + 32'h08;
    localparam logic [31:0] A_CHI  = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;
    localparam logic [31:0] A_STAT = BASE + 32'h14;

    logic        clk;
    logic        reset;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic        memwriteM;
    logic        csr_mtie_r;
    logic        tmr_sel;
    logic [31:0] tmr_rdata;
    logic        tmr_irq_r;

    int compareCount;
    int failCount;

    // Behavioural model: 64-bit time, compare value, control fields, and the
    // number of enabled cycles since the last CTRL write or reset.
    logic [63:0] mTime;
    logic [63:0] mCmp;
    logic        mEn;
    logic [7:0]  mPs;
    int          mElapsed;
    logic        mIrq;

    cpu6_tmr #(.BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataaddr   (dataaddr),
        .writedata  (writedata),
        .memwriteM  (memwriteM),
        .csr_mtie_r (csr_mtie_r),
        .tmr_sel    (tmr_sel),
        .tmr_rdata  (tmr_rdata),
        .tmr_irq_r  (tmr_irq_r)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (a[31:6] != BASE[31:6]) return 32'h0;
        case (a[5:2])
            4'h0: return mTime[31:0];
            4'h1: return mTime[63:32];
            4'h2: return mCmp[31:0];
            4'h3: return mCmp[63:32];
            4'h4: return {16'h0, mPs, 7'h0, mEn};
            4'h5: return {30'h0, mIrq, (mTime >= mCmp)};
            default: return 32'h0;
        endcase
    endfunction

    // Advances the model across one rising edge using pre-edge values
    task automatic modelEdge(input logic r, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic ie);
        logic        hit;
        logic        doTick;
        logic [63:0] nTime;
        if (r) begin
            mTime = 64'h0; mCmp = '1; mEn = 1'b0; mPs = 8'h0; mElapsed = 0; mIrq = 1'b0;
            return;
        end
        hit    = w && (a[31:6] == BASE[31:6]);
        doTick = mEn && ((mElapsed % (int'(mPs) + 1)) == int'(mPs));
        mIrq   = (mTime >= mCmp) && ie;
        nTime  = doTick ? mTime + 64'h1 : mTime;
        if (hit && a[5:2] == 4'h0) nTime = {mTime[63:32], d};
        if (hit && a[5:2] == 4'h1) nTime = {d, mTime[31:0]};
        if (hit && a[5:2] == 4'h2) mCmp[31:0] = d;
        if (hit && a[5:2] == 4'h3) mCmp[63:32] = d;
        if (hit && a[5:2] == 4'h4) begin
            mElapsed = 0;
            mEn = d[0];
            mPs = d[15:8];
        end else if (mEn) begin
            mElapsed = mElapsed + 1;
        end
        mTime = nTime;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check outputs against the model, take the edge
    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic ie);
        reset = r; dataaddr = a; memwriteM = w; writedata = d; csr_mtie_r = ie;
        #1;
        checkOutput("rdata", tmr_rdata, modelRead(a));
        checkOutput("sel", {31'h0, tmr_sel}, {31'h0, (a[31:6] == BASE[31:6])});
        checkOutput("irq", {31'h0, tmr_irq_r}, {31'h0, mIrq});
        @(posedge clk);
        modelEdge(r, a, w, d, ie);
        #1;
    endtask

    // Direct read against a fixed value, no clock edge
    task automatic checkRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        reset = 1'b0; dataaddr = a; memwriteM = 1'b0;
        #1;
        checkOutput(tag, tmr_rdata, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic        rw;
        logic        rie;
        int          waitCycles;

        compareCount = 0;
        failCount    = 0;
        reset = 1'b1; dataaddr = 32'h0; writedata = 32'h0; memwriteM = 1'b0; csr_mtie_r = 1'b0;
        modelEdge(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset: nothing counts, nothing pends
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, (i % 2) ? A_STAT : A_MLO, 1'b0, 32'h0, 1'b0);
        checkRead("idle_mtime", A_MLO, 32'h0);
        checkRead("idle_status", A_STAT, 32'h0);
        checkRead("reset_cmp_hi", A_CHI, 32'hFFFF_FFFF);

        // PRESCALE=3: one tick per four cycles
        applyStimulus(1'b0, A_CTRL, 1'b1, 32'h0000_0301, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, A_MLO, 1'b0, 32'h0, 1'b0);
        checkRead("presc3_mtime", A_MLO, 32'd10);
        checkRead("ctrl_readback", A_CTRL, 32'h0000_0301);

        // Compare match raises the interrupt
        applyStimulus(1'b1, A_MLO, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, A_CHI, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, A_CLO, 1'b1, 32'd5, 1'b1);
        applyStimulus(1'b0, A_CTRL, 1'b1, 32'h1, 1'b1);
        waitCycles = 0;
        while (tmr_irq_r !== 1'b1 && waitCycles < 20) begin
            applyStimulus(1'b0, A_MLO, 1'b0, 32'h0, 1'b1);
            waitCycles++;
        end
        checkOutput("irq_wait_cycles", waitCycles, 32'd6);
        checkRead("irq_status", A_STAT, 32'h3);
        applyStimulus(1'b0, A_CLO, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, A_CHI, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, A_STAT, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, A_STAT, 1'b0, 32'h0, 1'b1);
        checkOutput("irq_dropped", {31'h0, tmr_irq_r}, 32'h0);

        // 64-bit wrap
        applyStimulus(1'b0, A_CTRL, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, A_MHI, 1'b1, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, A_MLO, 1'b1, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b0, A_CTRL, 1'b1, 32'h1, 1'b0);
        applyStimulus(1'b0, A_MLO, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, A_MLO, 1'b0, 32'h0, 1'b0);
        checkRead("wrap_lo", A_MLO, 32'h0);
        checkRead("wrap_hi", A_MHI, 32'h0);

        // Write beats tick
        applyStimulus(1'b0, A_MLO, 1'b1, 32'h100, 1'b0);
        checkRead("wr_vs_tick0", A_MLO, 32'h100);
        applyStimulus(1'b0, A_MLO, 1'b0, 32'h0, 1'b0);
        checkRead("wr_vs_tick1", A_MLO, 32'h101);

        // MTIE gating and reset
        applyStimulus(1'b0, A_CTRL, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, A_CLO, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, A_CHI, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, A_STAT, 1'b0, 32'h0, 1'b0);
        checkRead("pend_nomtie", A_STAT, 32'h1);
        checkOutput("irq_nomtie", {31'h0, tmr_irq_r}, 32'h0);
        applyStimulus(1'b0, A_STAT, 1'b0, 32'h0, 1'b1);
        checkOutput("irq_mtie", {31'h0, tmr_irq_r}, 32'h1);
        applyStimulus(1'b1, A_STAT, 1'b0, 32'h0, 1'b1);
        checkOutput("irq_after_reset", {31'h0, tmr_irq_r}, 32'h0);
        checkRead("cmp_after_reset", A_CLO, 32'hFFFF_FFFF);

        // Random traffic with small compare values so the interrupt toggles
        for (int i = 0; i < 600; i++) begin
            ra  = ($urandom_range(0, 9) == 0) ? $urandom : (BASE | {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)});
            rw  = ($urandom_range(0, 5) == 0);
            rd  = $urandom;
            if (ra[5:2] == 4'h4) rd[15:8] = 8'($urandom_range(0, 3));
            if (ra[5:2] == 4'h2 || ra[5:2] == 4'h0) rd = $urandom_range(0, 60);
            if (ra[5:2] == 4'h1 || ra[5:2] == 4'h3) rd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            rie = ($urandom_range(0, 3) != 0);
            applyStimulus(($urandom_range(0, 99) == 0), ra, rw, rd, rie);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
